// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps sel over the enabled channels,
// holds each for DWELL cycles and samples y on the last cycle of the dwell.
// Ports: clk, rst (sync, active high), start, en_mask[3:0], y -> sel[1:0],
//        busy, done (1-cycle pulse), result[3:0] (loaded in the done cycle).
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] en_mask,
  input  logic       y,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic [3:0] result
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(DWELL - 1);

  state_t     state, state_n;
  logic [3:0] mask_q, mask_n;
  logic [3:0] acc, acc_n, acc_s;
  logic [3:0] cnt, cnt_n;
  logic [3:0] result_n;
  logic [1:0] sel_n;
  logic       busy_n, done_n;

  logic       low_ok, nxt_ok;
  logic [1:0] low_ch, nxt_ch;

  // Lowest enabled channel of the incoming mask.
  always_comb begin
    low_ok = 1'b0;
    low_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (en_mask[i]) begin
        low_ok = 1'b1;
        low_ch = 2'(i);
      end
    end
  end

  // Next enabled channel strictly above sel; none means scan is over.
  always_comb begin
    nxt_ok = 1'b0;
    nxt_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel))) begin
        nxt_ok = 1'b1;
        nxt_ch = 2'(i);
      end
    end
  end

  // Accumulator with this cycle's sample merged in.
  always_comb begin
    acc_s      = acc;
    acc_s[sel] = y;
  end

  always_comb begin
    state_n  = state;
    mask_n   = mask_q;
    acc_n    = acc;
    cnt_n    = cnt;
    sel_n    = sel;
    busy_n   = busy;
    done_n   = 1'b0;
    result_n = result;
    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          acc_n = 4'd0;
          if (low_ok) begin
            mask_n  = en_mask;
            sel_n   = low_ch;
            cnt_n   = 4'd0;
            busy_n  = 1'b1;
            state_n = SCAN;
          end else begin
            result_n = 4'd0;
            done_n   = 1'b1;
            state_n  = DONE;
          end
        end
      end
      SCAN: begin
        if (cnt != LAST) begin
          cnt_n = cnt + 4'd1;
        end else begin
          acc_n = acc_s;
          cnt_n = 4'd0;
          if (nxt_ok) begin
            sel_n = nxt_ch;
          end else begin
            result_n = acc_s;
            busy_n   = 1'b0;
            done_n   = 1'b1;
            state_n  = DONE;
          end
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mask_q <= 4'd0;
      acc    <= 4'd0;
      cnt    <= 4'd0;
      sel    <= 2'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 4'd0;
    end else begin
      state  <= state_n;
      mask_q <= mask_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      sel    <= sel_n;
      busy   <= busy_n;
      done   <= done_n;
      result <= result_n;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl: two instances (DWELL=2 and DWELL=3),
// each feeding y from a behavioural 4:1 mux; compared with a scan model.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start_a = 1'b0;
  logic [3:0] en_a = 4'd0;
  logic [3:0] d2 = 4'd0;
  logic       y_a;
  logic [1:0] sel_a;
  logic       busy_a, done_a;
  logic [3:0] res_a;

  logic       start_b = 1'b0;
  logic [3:0] en_b = 4'd0;
  logic [3:0] d3 = 4'd0;
  logic       y_b;
  logic [1:0] sel_b;
  logic       busy_b, done_b;
  logic [3:0] res_b;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_res_a = 4'd0;
  logic [1:0] exp_sel_a = 2'd0;
  logic [3:0] exp_res_b = 4'd0;

  localparam int DA = 2;
  localparam int DB = 3;

  assign y_a = d2[sel_a];
  assign y_b = d3[sel_b];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL(DA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .en_mask(en_a), .y(y_a),
    .sel(sel_a), .busy(busy_a), .done(done_a), .result(res_a)
  );

  mux_scan_ctrl #(.DWELL(DB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .en_mask(en_b), .y(y_b),
    .sel(sel_b), .busy(busy_b), .done(done_b), .result(res_b)
  );

  task automatic test_reset();
    checks++;
    if ({sel_a, busy_a, done_a, res_a} !== 8'd0) begin
      errors++;
      $display("FAIL reset_a: sel=%b busy=%b done=%b result=%b want all 0",
               sel_a, busy_a, done_a, res_a);
    end
    checks++;
    if ({sel_b, busy_b, done_b, res_b} !== 8'd0) begin
      errors++;
      $display("FAIL reset_b: sel=%b busy=%b done=%b result=%b want all 0",
               sel_b, busy_b, done_b, res_b);
    end
  endtask

  // One scan on the DWELL=2 instance with d2 held constant, so the
  // expected result is simply the mux inputs masked by the enables.
  task automatic run_scan(input string nm, input logic [3:0] m,
                          input bit disturb);
    int chans[$];
    int n;
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) if (m[i]) chans.push_back(i);
    n = chans.size();
    exp = d2 & m;
    @(negedge clk);
    start_a = 1'b1;
    en_a = m;
    @(negedge clk);
    start_a = 1'b0;
    if (n == 0) begin
      checks++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || res_a !== 4'd0 ||
          sel_a !== exp_sel_a) begin
        errors++;
        $display("FAIL %s_empty: done=%b busy=%b res=%b sel=%b want 1 0 0000 %b",
                 nm, done_a, busy_a, res_a, sel_a, exp_sel_a);
      end
      exp_res_a = 4'd0;
    end else begin
      for (int c = 0; c < n * DA; c++) begin
        checks++;
        if (sel_a !== 2'(chans[c / DA]) || busy_a !== 1'b1 ||
            done_a !== 1'b0 || res_a !== exp_res_a) begin
          errors++;
          $display("FAIL %s_cyc%0d: sel=%b busy=%b done=%b res=%b want %0d 1 0 %b",
                   nm, c, sel_a, busy_a, done_a, res_a, chans[c / DA],
                   exp_res_a);
        end
        if (disturb && c == 1) begin
          start_a = 1'b1;
          en_a = 4'b0001;
        end
        if (disturb && c == 2) start_a = 1'b0;
        @(negedge clk);
      end
      exp_res_a = exp;
      exp_sel_a = 2'(chans[n - 1]);
      checks++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || res_a !== exp_res_a ||
          sel_a !== exp_sel_a) begin
        errors++;
        $display("FAIL %s_done: done=%b busy=%b res=%b sel=%b want 1 0 %b %b",
                 nm, done_a, busy_a, res_a, sel_a, exp_res_a, exp_sel_a);
      end
    end
    for (int k = 0; k < (disturb ? 4 : 1); k++) begin
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || res_a !== exp_res_a) begin
        errors++;
        $display("FAIL %s_after%0d: done=%b busy=%b res=%b want 0 0 %b",
                 nm, k, done_a, busy_a, res_a, exp_res_a);
      end
    end
  endtask

  // Scan on the DWELL=3 instance; y may change every cycle and the model
  // keeps whatever the channel's input was during its last dwell cycle.
  task automatic run_scan_b(input string nm, input logic [3:0] m,
                            input bit rnd);
    int chans[$];
    int n;
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) if (m[i]) chans.push_back(i);
    n = chans.size();
    exp = 4'd0;
    @(negedge clk);
    start_b = 1'b1;
    en_b = m;
    @(negedge clk);
    start_b = 1'b0;
    en_b = ~m;
    for (int c = 0; c < n * DB; c++) begin
      if (rnd) d3 = 4'($urandom);
      else if (c == 1) d3 = 4'b0001;
      if (c % DB == DB - 1) exp[chans[c / DB]] = d3[chans[c / DB]];
      checks++;
      if (sel_b !== 2'(chans[c / DB]) || busy_b !== 1'b1 ||
          done_b !== 1'b0 || res_b !== exp_res_b) begin
        errors++;
        $display("FAIL %s_cyc%0d: sel=%b busy=%b done=%b res=%b want %0d 1 0 %b",
                 nm, c, sel_b, busy_b, done_b, res_b, chans[c / DB],
                 exp_res_b);
      end
      @(negedge clk);
    end
    exp_res_b = exp;
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || res_b !== exp_res_b) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b res=%b want 1 0 %b",
               nm, done_b, busy_b, res_b, exp_res_b);
    end
    @(negedge clk);
    checks++;
    if (done_b !== 1'b0 || res_b !== exp_res_b) begin
      errors++;
      $display("FAIL %s_after: done=%b res=%b want 0 %b",
               nm, done_b, res_b, exp_res_b);
    end
  endtask

  task automatic test_full_scan();
    d2 = 4'b1010;
    run_scan("full", 4'b1111, 1'b0);
  endtask

  task automatic test_partial_mask();
    d2 = 4'b1010;
    run_scan("partial", 4'b1100, 1'b0);
  endtask

  task automatic test_empty_mask();
    run_scan("empty", 4'b0000, 1'b0);
  endtask

  task automatic test_ignored_start();
    d2 = 4'b0110;
    run_scan("ignored", 4'b1011, 1'b1);
  endtask

  // start held high: the next scan is accepted N*DWELL+2 cycles later.
  task automatic test_back_to_back();
    logic [6:0] eb;
    logic [6:0] ed;
    eb = 7'b0110011;
    ed = 7'b1000100;
    d2 = 4'b0010;
    @(negedge clk);
    start_a = 1'b1;
    en_a = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 4) start_a = 1'b0;
      checks++;
      if (busy_a !== eb[c] || done_a !== ed[c] || sel_a !== 2'd1) begin
        errors++;
        $display("FAIL b2b_cyc%0d: busy=%b done=%b sel=%b want %b %b 01",
                 c, busy_a, done_a, sel_a, eb[c], ed[c]);
      end
    end
    exp_res_a = 4'b0010;
    exp_sel_a = 2'd1;
    checks++;
    if (res_a !== exp_res_a) begin
      errors++;
      $display("FAIL b2b_result: res=%b want %b", res_a, exp_res_a);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      d2 = 4'($urandom);
      run_scan("rand_a", 4'($urandom), 1'b0);
    end
  endtask

  task automatic test_reset_mid_scan();
    d2 = 4'b1010;
    @(negedge clk);
    start_a = 1'b1;
    en_a = 4'b1111;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_res_a = 4'd0;
    exp_sel_a = 2'd0;
    exp_res_b = 4'd0;
    checks++;
    if (sel_a !== 2'd0 || busy_a !== 1'b0 || res_a !== 4'd0 ||
        done_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: sel=%b busy=%b res=%b done=%b want 00 0 0000 0",
               sel_a, busy_a, res_a, done_a);
    end
    run_scan("post_rst", 4'b1111, 1'b0);
  endtask

  task automatic test_dwell_sampling();
    d3 = 4'b0000;
    run_scan_b("dwell", 4'b0001, 1'b0);
    checks++;
    if (res_b[0] !== 1'b1) begin
      errors++;
      $display("FAIL dwell_bit0: result[0]=%b want 1", res_b[0]);
    end
  endtask

  task automatic test_random_dwell();
    for (int t = 0; t < 6; t++) begin
      run_scan_b("rand_b", 4'($urandom_range(1, 15)), 1'b1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_full_scan();
    test_partial_mask();
    test_empty_mask();
    test_ignored_start();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
    test_dwell_sampling();
    test_random_dwell();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
